bcd_counter_chain: RTL and testbench
====================================

# bcd_counter_chain

Parametrised multi-digit BCD (decade) counter with enable, synchronous clear, parallel load, programmable prescaler and a registered terminal-count carry pulse. It is the general counting primitive for the LED/7-segment daughterboard designs, replacing single-digit decade counters. A chain of `DIGITS` decade stages is driven by one clock, with ripple-free, same-cycle digit carries. An optional down-count mode is available.

## Interface
Parameters:
- `DIGITS`, default 2: number of BCD digits. Range 1..8.
- `PRESCALE`, default 1: enabled clock cycles per count step. Range 1..65535.

Ports:
- `clk` in 1: the single clock. All state is on the rising edge.
- `rst` in 1: reset, asynchronous, active-low. Clears all state.
- `en` in 1: count enable. When low, the counter and prescaler are frozen.
- `clr` in 1: synchronous clear of the count and prescaler.
- `load` in 1: synchronous parallel load.
- `load_val` in 4*DIGITS: BCD load value. Digit *i* is `load_val[4i+3:4i]`.
- `dir` in 1: count direction, 1 = down, 0 = up. Present only with `BCD_CNT_DOWN_EN`.
- `cnt` out 4*DIGITS: current count, packed BCD. The least significant digit is in bits [3:0].
- `carry` out 1: one-cycle pulse on wrap (up) or borrow (down).
- `step` out 1: one-cycle pulse on every cycle in which the count advanced.

## Operation
- Reset (`rst`=0, asynchronous): `cnt`=0, `carry`=0, `step`=0, prescaler=0.
- Priority per edge: `clr` > `load` > count step.
- `clr`:
  - Sets `cnt`=0 and prescaler=0.
  - Forces `carry`=0 and `step`=0.
- `load`:
  - Sets `cnt`=`load_val` and prescaler=0.
  - Forces `carry`=0 and `step`=0.
  - Any loaded digit greater than 9 is stored as 9 (per-digit saturation).
- Prescaler:
  - Counter of width $clog2(PRESCALE) (minimum 1).
  - When `en`=1, it increments each cycle.
  - When it equals PRESCALE-1, it returns to 0 and a step is generated.
  - With PRESCALE=1, every enabled cycle is a step.
- Count step, up:
  - Digit 0 increments.
  - A digit at 9 goes to 0 and propagates an increment to the next digit in the same cycle.
- Count step, down:
  - Digit 0 decrements.
  - A digit at 0 goes to 9 and propagates a borrow to the next digit.
- Terminal conditions:
  - Up: all digits are 9.
  - Down: all digits are 0.
  - A step taken from the terminal condition wraps `cnt` (to all 0s up, to all 9s down) and sets `carry`=1 on that same edge.
  - `carry` is 0 on all other edges.
- `step` is registered: high for one cycle after each edge on which the count advanced.
- `en`=0: `cnt` and the prescaler hold; `carry` and `step` return to 0.
- No digit ever holds a value greater than 9.

## Timing
- Latency from the step edge to the new `cnt`: 0. `cnt` is a register updated on the step edge.
- `carry` and `step` are registered and aligned with the updated `cnt`. For example, `carry`=1 while `cnt` shows 00 after the 99→00 wrap.
- Carry across digits is combinational within one cycle. The full chain resolves in one clock; there is no ripple latency.
- A `clr` or `load` asserted on the same edge as a terminal step wins. No carry is generated.
- Reset asserted mid-count acts immediately (asynchronous). Release is synchronous to the next `clk` edge; the first step occurs PRESCALE enabled cycles after release.
- A `dir` change takes effect on the next step. The prescaler phase is not disturbed.
- PRESCALE=1 with `en` held high produces a continuous `step`=1.

## Configuration
- Macro `BCD_CNT_DOWN_EN`.
- Defined:
  - The `dir` port exists.
  - Down counting and borrow-on-carry are as described above.
- Undefined:
  - No `dir` port; the counter is up-only.
  - The decrement and borrow logic is not generated.
  - All other behaviour is identical.

## Structure
- Package `bcd_counter_pkg`:
  - `BCD_W`=4.
  - `BCD_MAX`=4'd9.
  - `typedef logic [3:0] bcd_t`.
  - Saturating conversion function `bcd_sat(bcd_t)`.
- Sub-module `bcd_digit`: one decade stage, instantiated DIGITS times via generate.
  - Inputs: `inc`, `dec`, `ld`, `ld_val`, `clr`.
  - Outputs: the digit value, `co` (at 9 and incrementing) and `bo` (at 0 and decrementing).
- Top level holds the prescaler, priority decode, terminal detect, and the `carry`/`step` registers.

## Test plan
All cases use DIGITS=2 and PRESCALE=1 unless stated.
- Reset at `cnt`=37 mid-run → `cnt`=00, `carry`=0, `step`=0 immediately, without waiting for a clock edge.
- Load 98, `en`=1 for 3 cycles → `cnt` 99, 00, 01. `carry`=1 only in the cycle showing 00.
- Load 0xA5 → `cnt`=95. Load 0x3F → `cnt`=39.
- PRESCALE=4, `en`=1 for 12 cycles from 00 → `cnt`=03, with `step` pulsing every 4th cycle. Drop `en` for 5 cycles → `cnt` holds at 03.
- `clr` and `load`(55) together on the 99→00 step edge → `cnt`=00, `carry`=0.
- `BCD_CNT_DOWN_EN`, `dir`=1 from 01 → `cnt` 00, 99 (`carry`=1 here), 98. Toggle `dir`=0 → `cnt` 99.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared BCD types, constants and the per-digit saturation helper for bcd_counter_chain.
package bcd_counter_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Non-decimal nibbles clamp to 9 so a digit can never leave the 0..9 range.
    function automatic bcd_t bcd_sat(bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade stage: clear > load > increment/decrement, with same-cycle carry/borrow outputs.
module bcd_digit
    import bcd_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic ld,
    input  bcd_t ld_val,
    input  logic clr,
    output bcd_t val,
    output logic co,
    output logic bo
);

    bcd_t val_d;

    assign co = inc && (val == BCD_MAX);
    assign bo = dec && (val == '0);

    always_comb begin
        val_d = val;
        if (clr) begin
            val_d = '0;
        end else if (ld) begin
            val_d = bcd_sat(ld_val);
        end else if (inc) begin
            val_d = (val == BCD_MAX) ? '0 : val + 4'd1;
        end else if (dec) begin
            val_d = (val == '0) ? BCD_MAX : val - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val <= '0;
        end else begin
            val <= val_d;
        end
    end

endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD counter with prescaler, clear/load and registered carry/step pulses.
// Define BCD_CNT_DOWN_EN to add the dir port and down counting with borrow.
module bcd_counter_chain
    import bcd_counter_pkg::*;
#(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
`ifdef BCD_CNT_DOWN_EN
    input  logic                    dir,
`endif
    output logic [BCD_W*DIGITS-1:0] cnt,
    output logic                    carry,
    output logic                    step
);

    localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc_q, psc_d;
    logic             tick, adv, adv_up, adv_dn, down, wrap;
    logic [DIGITS-1:0] inc, dec, co, bo;

`ifdef BCD_CNT_DOWN_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif

    assign tick   = en && (psc_q == PSC_LAST);
    assign adv    = tick && !clr && !load;
    assign adv_up = adv && !down;
    assign adv_dn = adv && down;
    // The top digit's carry/borrow only fires when every lower digit also rolled over.
    assign wrap   = down ? bo[DIGITS-1] : co[DIGITS-1];

    always_comb begin
        psc_d = psc_q;
        if (clr || load) begin
            psc_d = '0;
        end else if (en) begin
            psc_d = tick ? '0 : psc_q + 1'b1;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign inc[i] = adv_up;
            assign dec[i] = adv_dn;
        end else begin : g_upper
            assign inc[i] = co[i-1];
            assign dec[i] = bo[i-1];
        end

        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .inc    (inc[i]),
            .dec    (dec[i]),
            .ld     (load),
            .ld_val (load_val[BCD_W*i +: BCD_W]),
            .clr    (clr),
            .val    (cnt[BCD_W*i +: BCD_W]),
            .co     (co[i]),
            .bo     (bo[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc_q <= '0;
            carry <= 1'b0;
            step  <= 1'b0;
        end else begin
            psc_q <= psc_d;
            carry <= wrap;
            step  <= adv;
        end
    end

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Scoreboard bench: two-digit counters with PRESCALE 1 and 4 share stimulus against an integer model.
module tb_bcd_counter_chain;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       dir_b = 1'b0;

    logic [7:0] cnt1, cnt4;
    logic       carry1, carry4, step1, step4;

    int total = 0;
    int bad = 0;

    int v1 = 0, p1 = 0, v4 = 0, p4 = 0;

    typedef struct {
        logic [7:0] c1;
        logic       cy1;
        logic       st1;
        logic [7:0] c4;
        logic       cy4;
        logic       st4;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_counter_chain #(.DIGITS(2), .PRESCALE(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
`ifdef BCD_CNT_DOWN_EN
        .dir      (dir_b),
`endif
        .cnt      (cnt1),
        .carry    (carry1),
        .step     (step1)
    );

    bcd_counter_chain #(.DIGITS(2), .PRESCALE(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
`ifdef BCD_CNT_DOWN_EN
        .dir      (dir_b),
`endif
        .cnt      (cnt4),
        .carry    (carry4),
        .step     (step4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic int from_load(input logic [7:0] lv);
        int hi, lo;
        hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
        lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
        return hi * 10 + lo;
    endfunction

    task automatic model_step(inout int v, inout int p, input int pre,
                              output logic cy, output logic st);
        cy = 1'b0;
        st = 1'b0;
        if (clr) begin
            v = 0;
            p = 0;
        end else if (load) begin
            v = from_load(load_val);
            p = 0;
        end else if (en) begin
            if (p == pre - 1) begin
                p  = 0;
                st = 1'b1;
                if (dir_b) begin
                    cy = (v == 0);
                    v  = (v + 99) % 100;
                end else begin
                    cy = (v == 99);
                    v  = (v + 1) % 100;
                end
            end else begin
                p = p + 1;
            end
        end
    endtask

    task automatic cycle(input logic e, input logic c, input logic l, input logic [7:0] lv);
        exp_t x, got;
        en       = e;
        clr      = c;
        load     = l;
        load_val = lv;
        model_step(v1, p1, 1, x.cy1, x.st1);
        model_step(v4, p4, 4, x.cy4, x.st4);
        x.c1 = to_bcd(v1);
        x.c4 = to_bcd(v4);
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("cnt1", 32'(cnt1), 32'(got.c1));
        check("carry1", 32'(carry1), 32'(got.cy1));
        check("step1", 32'(step1), 32'(got.st1));
        check("cnt4", 32'(cnt4), 32'(got.c4));
        check("carry4", 32'(carry4), 32'(got.cy4));
        check("step4", 32'(step4), 32'(got.st4));
    endtask

    initial begin
        #12;
        check("rst_cnt1", 32'(cnt1), 32'h0);
        check("rst_cnt4", 32'(cnt4), 32'h0);
        check("rst_carry1", 32'(carry1), 32'h0);
        check("rst_step1", 32'(step1), 32'h0);
        rst = 1'b1;

        // Reach 37 on the PRESCALE=1 counter, then reset asynchronously mid-cycle.
        cycle(1'b0, 1'b0, 1'b1, 8'h30);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("pre_rst_cnt1", 32'(cnt1), 32'h37);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_cnt1", 32'(cnt1), 32'h0);
        check("arst_cnt4", 32'(cnt4), 32'h0);
        check("arst_step1", 32'(step1), 32'h0);
        check("arst_carry1", 32'(carry1), 32'h0);
        v1 = 0; p1 = 0; v4 = 0; p4 = 0;
        #1;
        rst = 1'b1;

        // Prescaler: 12 enabled cycles, then 5 frozen cycles.
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("psc_cnt4", 32'(cnt4), 32'h03);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("hold_cnt4", 32'(cnt4), 32'h03);

        // Load saturation.
        cycle(1'b0, 1'b0, 1'b1, 8'hA5);
        check("sat_a5", 32'(cnt1), 32'h95);
        cycle(1'b0, 1'b0, 1'b1, 8'h3F);
        check("sat_3f", 32'(cnt1), 32'h39);

        // 98 -> 99 -> 00 (carry) -> 01.
        cycle(1'b0, 1'b0, 1'b1, 8'h98);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("wrap_cnt1", 32'(cnt1), 32'h01);

        // clr/load on the terminal step edge suppress the carry.
        cycle(1'b0, 1'b0, 1'b1, 8'h99);
        cycle(1'b1, 1'b1, 1'b1, 8'h55);
        check("clr_term_cnt1", 32'(cnt1), 32'h00);
        check("clr_term_carry1", 32'(carry1), 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 8'h99);
        cycle(1'b1, 1'b0, 1'b1, 8'h55);
        check("ld_term_cnt1", 32'(cnt1), 32'h55);

`ifdef BCD_CNT_DOWN_EN
        cycle(1'b0, 1'b0, 1'b1, 8'h01);
        dir_b = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("dn_00", 32'(cnt1), 32'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("dn_99", 32'(cnt1), 32'h99);
        check("dn_borrow", 32'(carry1), 32'h1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("dn_98", 32'(cnt1), 32'h98);
        dir_b = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("up_99", 32'(cnt1), 32'h99);
`endif

        // Random mix, mostly counting, with occasional clear/load of arbitrary nibbles.
        for (int i = 0; i < 300; i++) begin
            logic re, rc, rl;
            re = ($urandom_range(0, 9) != 0);
            rc = ($urandom_range(0, 29) == 0);
            rl = ($urandom_range(0, 14) == 0);
`ifdef BCD_CNT_DOWN_EN
            if ($urandom_range(0, 19) == 0) dir_b = ~dir_b;
`endif
            cycle(re, rc, rl, 8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
